// File: rtl/write_stack_offset_pkg.sv
// Shared ao486 defines: descriptor bit positions plus the write-stage
// stack-offset FSM encoding and the ESP commit-value helpers.
package write_stack_offset_pkg;

    localparam int DESC_BIT_G    = 55;
    localparam int DESC_BIT_D_B  = 54;
    localparam int DESC_BIT_AVL  = 52;
    localparam int DESC_BIT_P    = 47;
    localparam int DESC_BIT_SEG  = 44;

    typedef enum logic [1:0] {
        WSO_IDLE   = 2'd0,
        WSO_SEQ    = 2'd1,
        WSO_COMMIT = 2'd2
    } wso_state_e;

    // A 16-bit stack only replaces SP; the upper half of ESP is preserved.
    function automatic logic [31:0] wso_commit_value(
        input logic        d_b,
        input logic [31:0] esp_val,
        input logic [31:0] offset
    );
        return d_b ? offset : {esp_val[31:16], offset[15:0]};
    endfunction

    function automatic logic [31:0] wso_limit_offset(
        input logic        d_b,
        input logic [31:0] offset
    );
        return d_b ? offset : {16'd0, offset[15:0]};
    endfunction

endpackage

// File: rtl/write_stack_offset.sv
// Write-stage stack offset chaining and ESP commit.
// Optional SS limit check enabled by defining WR_STACK_LIMIT_CHECK_EN.
module write_stack_offset
    import write_stack_offset_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_ready,
    input  logic [31:0] exe_stack_offset,
    input  logic        exe_stack_use,
    input  logic        exe_stack_first,
    input  logic        exe_stack_last,
    input  logic        ss_d_b,
    input  logic [31:0] ss_limit,
    input  logic        wr_flush,
    input  logic [31:0] esp,
    output logic [31:0] wr_stack_offset,
    output logic        wr_esp_write,
    output logic [31:0] wr_esp_value,
    output logic        wr_stack_busy,
    output logic        wr_stack_fault
);

    wso_state_e  state_q, state_d;
    logic [31:0] offset_q, offset_d;
    logic        accept;
    logic        commit_cycle;
    logic [31:0] commit_value;

    assign accept = exe_ready & exe_stack_use;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        if (wr_flush) begin
            state_d  = WSO_IDLE;
            offset_d = esp;
        end else begin
            case (state_q)
                // COMMIT behaves like IDLE so back-to-back sequences need no bubble.
                WSO_IDLE, WSO_COMMIT: begin
                    state_d = WSO_IDLE;
                    if (accept && exe_stack_first) begin
                        offset_d = exe_stack_offset;
                        state_d  = exe_stack_last ? WSO_COMMIT : WSO_SEQ;
                    end
                end
                WSO_SEQ: begin
                    // A new 'first' here simply restarts the chain with its offset.
                    if (accept) begin
                        offset_d = exe_stack_offset;
                        if (exe_stack_last) begin
                            state_d = WSO_COMMIT;
                        end
                    end
                end
                default: begin
                    state_d = WSO_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WSO_IDLE;
            offset_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
        end
    end

    assign commit_cycle = (state_q == WSO_COMMIT) && !wr_flush;
    assign commit_value = wso_commit_value(ss_d_b, esp, offset_q);

    assign wr_stack_offset = offset_q;
    assign wr_stack_busy   = (state_q == WSO_SEQ);
    assign wr_esp_value    = commit_cycle ? commit_value : 32'd0;

`ifdef WR_STACK_LIMIT_CHECK_EN
    logic over_limit;

    assign over_limit     = wso_limit_offset(ss_d_b, offset_q) > ss_limit;
    assign wr_stack_fault = commit_cycle && over_limit;
    assign wr_esp_write   = commit_cycle && !over_limit;
`else
    logic limit_unused;

    assign limit_unused   = ^ss_limit;
    assign wr_stack_fault = 1'b0;
    assign wr_esp_write   = commit_cycle;
`endif

endmodule

// File: tb/tb_write_stack_offset.sv
// Scoreboard bench for write_stack_offset: directed vectors push expected
// ESP commits/faults; a negedge monitor pops and compares them.
module tb_write_stack_offset;

    logic        clk;
    logic        rst;
    logic        exe_ready;
    logic [31:0] exe_stack_offset;
    logic        exe_stack_use;
    logic        exe_stack_first;
    logic        exe_stack_last;
    logic        ss_d_b;
    logic [31:0] ss_limit;
    logic        wr_flush;
    logic [31:0] esp;
    logic [31:0] wr_stack_offset;
    logic        wr_esp_write;
    logic [31:0] wr_esp_value;
    logic        wr_stack_busy;
    logic        wr_stack_fault;

    typedef struct {
        logic        fault;
        logic [31:0] value;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    write_stack_offset dut (
        .clk              (clk),
        .rst              (rst),
        .exe_ready        (exe_ready),
        .exe_stack_offset (exe_stack_offset),
        .exe_stack_use    (exe_stack_use),
        .exe_stack_first  (exe_stack_first),
        .exe_stack_last   (exe_stack_last),
        .ss_d_b           (ss_d_b),
        .ss_limit         (ss_limit),
        .wr_flush         (wr_flush),
        .esp              (esp),
        .wr_stack_offset  (wr_stack_offset),
        .wr_esp_write     (wr_esp_write),
        .wr_esp_value     (wr_esp_value),
        .wr_stack_busy    (wr_stack_busy),
        .wr_stack_fault   (wr_stack_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every commit/fault strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                exp_t m;
                m = sb_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_commit: cycle %0d no strobe seen, required fault=%0b value=%h",
                         m.cyc, m.fault, m.value);
            end
            if (wr_esp_write || wr_stack_fault) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_commit: cycle %0d got write=%0b fault=%0b value=%h, required none",
                             cyc, wr_esp_write, wr_stack_fault, wr_esp_value);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (wr_stack_fault !== e.fault || wr_esp_write !== !e.fault ||
                        (!e.fault && wr_esp_value !== e.value) || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL commit: cycle %0d write=%0b fault=%0b value=%h, required cycle %0d fault=%0b value=%h",
                                 cyc, wr_esp_write, wr_stack_fault, wr_esp_value, e.cyc, e.fault, e.value);
                    end else begin
                        $display("commit ok: cycle %0d fault=%0b value=%h", cyc, e.fault, wr_esp_value);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] off, input logic use_b, input logic first, input logic last);
        exe_ready        = 1'b1;
        exe_stack_offset = off;
        exe_stack_use    = use_b;
        exe_stack_first  = first;
        exe_stack_last   = last;
    endtask

    task automatic quiet();
        exe_ready        = 1'b0;
        exe_stack_offset = 32'h0;
        exe_stack_use    = 1'b0;
        exe_stack_first  = 1'b0;
        exe_stack_last   = 1'b0;
        wr_flush         = 1'b0;
    endtask

    task automatic expect_commit(input logic fault, input logic [31:0] value);
        exp_t e;
        e.fault = fault;
        e.value = value;
        e.cyc   = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        rst      = 1'b1;
        ss_d_b   = 1'b1;
        ss_limit = 32'hFFFF_FFFF;
        esp      = 32'h0000_1000;
        // Reset must override both flush and a live transfer.
        wr_flush = 1'b1;
        drive(32'h1234_5678, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        @(negedge clk);
        chk("rst_offset", wr_stack_offset, 32'h0);
        chk("rst_write_fault_busy", {29'd0, wr_esp_write, wr_stack_fault, wr_stack_busy}, 32'h0);
        chk("rst_esp_value", wr_esp_value, 32'h0);

        // Single push, issued in the first cycle after reset release.
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_flush = 1'b0;
        drive(32'h0000_0FFC, 1'b1, 1'b1, 1'b1);
        expect_commit(1'b0, 32'h0000_0FFC);
        tick();
        quiet();
        @(negedge clk);
        chk("push_offset", wr_stack_offset, 32'h0000_0FFC);
        tick();

        // 16-bit stack keeps ESP upper half.
        esp    = 32'hABCD_0010;
        ss_d_b = 1'b0;
        drive(32'h0000_000E, 1'b1, 1'b1, 1'b1);
        expect_commit(1'b0, 32'hABCD_000E);
        tick();
        quiet();
        tick();

        // Three-step sequence.
        ss_d_b = 1'b1;
        esp    = 32'h0000_0200;
        drive(32'h0000_01FC, 1'b1, 1'b1, 1'b0);
        tick();
        drive(32'h0000_01F8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("seq1_busy", {31'd0, wr_stack_busy}, 32'd1);
        chk("seq1_offset", wr_stack_offset, 32'h0000_01FC);
        tick();
        drive(32'h0000_01F4, 1'b1, 1'b0, 1'b1);
        expect_commit(1'b0, 32'h0000_01F4);
        @(negedge clk);
        chk("seq2_busy", {31'd0, wr_stack_busy}, 32'd1);
        chk("seq2_offset", wr_stack_offset, 32'h0000_01F8);
        tick();
        quiet();
        @(negedge clk);
        chk("seq3_busy", {31'd0, wr_stack_busy}, 32'd0);
        chk("seq3_offset", wr_stack_offset, 32'h0000_01F4);
        tick();

        // use=0 in SEQ is ignored; a new first restarts the chain.
        drive(32'h0000_0300, 1'b1, 1'b1, 1'b0);
        tick();
        drive(32'h0000_0999, 1'b0, 1'b0, 1'b1);
        tick();
        quiet();
        @(negedge clk);
        chk("nouse_busy", {31'd0, wr_stack_busy}, 32'd1);
        chk("nouse_offset", wr_stack_offset, 32'h0000_0300);
        drive(32'h0000_0400, 1'b1, 1'b1, 1'b0);
        tick();
        quiet();
        @(negedge clk);
        chk("restart_offset", wr_stack_offset, 32'h0000_0400);

        // Flush beats a concurrent last transfer.
        wr_flush = 1'b1;
        esp      = 32'h0000_0200;
        drive(32'h0000_01F8, 1'b1, 1'b0, 1'b1);
        tick();
        quiet();
        @(negedge clk);
        chk("flush_busy", {31'd0, wr_stack_busy}, 32'd0);
        chk("flush_offset", wr_stack_offset, 32'h0000_0200);
        tick();

        // Flush arriving in COMMIT suppresses that commit.
        drive(32'h0000_0500, 1'b1, 1'b1, 1'b1);
        tick();
        quiet();
        wr_flush = 1'b1;
        esp      = 32'h0000_0600;
        tick();
        wr_flush = 1'b0;
        @(negedge clk);
        chk("flush_commit_offset", wr_stack_offset, 32'h0000_0600);
        tick();

        // Non-first transfer in IDLE is ignored.
        drive(32'h0000_0777, 1'b1, 1'b0, 1'b1);
        tick();
        quiet();
        @(negedge clk);
        chk("idle_nonfirst_offset", wr_stack_offset, 32'h0000_0600);
        tick();

        // Back-to-back: last then first=last with no bubble.
        esp = 32'h0000_1000;
        drive(32'h0000_2000, 1'b1, 1'b1, 1'b0);
        tick();
        drive(32'h0000_0FFC, 1'b1, 1'b0, 1'b1);
        expect_commit(1'b0, 32'h0000_0FFC);
        tick();
        drive(32'h0000_0FF8, 1'b1, 1'b1, 1'b1);
        expect_commit(1'b0, 32'h0000_0FF8);
        tick();
        quiet();
        tick();

        // Limit boundary cases.
        ss_limit = 32'h0000_0FFF;
        drive(32'h0000_1000, 1'b1, 1'b1, 1'b1);
`ifdef WR_STACK_LIMIT_CHECK_EN
        expect_commit(1'b1, 32'h0000_1000);
`else
        expect_commit(1'b0, 32'h0000_1000);
`endif
        tick();
        quiet();
        tick();
        drive(32'h0000_0FFF, 1'b1, 1'b1, 1'b1);
        expect_commit(1'b0, 32'h0000_0FFF);
        tick();
        quiet();
        tick();
        esp    = 32'hABCD_1000;
        ss_d_b = 1'b0;
        drive(32'h0001_0FFE, 1'b1, 1'b1, 1'b1);
        expect_commit(1'b0, 32'hABCD_0FFE);
        tick();
        quiet();
        tick();

        // Mid-run reset clears the chained offset.
        drive(32'h0000_0800, 1'b1, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        quiet();
        @(negedge clk);
        chk("rerst_offset", wr_stack_offset, 32'h0);
        chk("rerst_busy", {31'd0, wr_stack_busy}, 32'd0);

        tick();
        tick();
        @(negedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
